// File: rtl/tpu_host_dma_if.sv
// Signal bundle between the host DMA engine and its environment:
// command, write/read streams, tpu bus and status.
interface tpu_host_dma_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [13:0] cmd_word_addr;
  logic [13:0] cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        axi_req;
  logic        axi_we;
  logic [63:0] axi_addr;
  logic [63:0] axi_wdata;
  logic [63:0] axi_rdata;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  cmd_valid, cmd_op, cmd_word_addr, cmd_len, in_valid, in_data, out_ready, axi_rdata,
    output cmd_ready, in_ready, out_valid, out_data, axi_req, axi_we, axi_addr, axi_wdata,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_word_addr, cmd_len, in_valid, in_data, out_ready, axi_rdata,
    input  cmd_ready, in_ready, out_valid, out_data, axi_req, axi_we, axi_addr, axi_wdata,
    input  busy, done, err
  );
endinterface

// File: rtl/tpu_host_dma.sv
// Host-side bus master for tpu: streams words into/out of UBUF/ICACHE and runs
// kernels by toggling EN and polling FINISH. One bus access outstanding at a time.
module tpu_host_dma #(
  parameter logic [63:0] BASE_ADDR     = 64'h4000_0000,
  parameter int unsigned POLL_GAP      = 8,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input logic            clk,
  input logic            rst,
  tpu_host_dma_if.master bus
);
  localparam logic [1:0]  OP_WRITE   = 2'd0;
  localparam logic [1:0]  OP_READ    = 2'd1;
  localparam logic [1:0]  OP_RUN     = 2'd2;
  localparam logic [13:0] EN_IDX     = 14'h2E00;
  localparam logic [13:0] FINISH_IDX = 14'h2E01;
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int PC_W  = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR, ST_RD_REQ, ST_RD_WAIT, ST_RD_OUT, ST_RUN_EN,
    ST_POLL_REQ, ST_POLL_WAIT, ST_POLL_GAP, ST_RUN_CLR, ST_FIN
  } state_t;

  state_t            state_reg, state_next;
  logic [13:0]       addr_reg, addr_next;
  logic [13:0]       rem_reg, rem_next;
  logic [PC_W-1:0]   poll_cnt_reg, poll_cnt_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic              abort_reg, abort_next;
  logic [63:0]       out_data_reg, out_data_next;
  logic              cmd_ready_reg, cmd_ready_next;
  logic              axi_req_reg, axi_req_next;
  logic              axi_we_reg, axi_we_next;
  logic [63:0]       axi_addr_reg, axi_addr_next;
  logic [63:0]       axi_wdata_reg, axi_wdata_next;
  logic [14:0]       last_idx;
  logic              range_ok;
  logic              in_ready_w;

  function automatic logic [63:0] byte_addr(input logic [13:0] idx);
    return BASE_ADDR + {47'd0, idx, 3'b000};
  endfunction

  // The range must sit wholly inside one buffer; 15-bit sum so an overflowing end is caught.
  assign last_idx = {1'b0, bus.cmd_word_addr} + {1'b0, bus.cmd_len} - 15'd1;
  assign range_ok = (last_idx <= 15'h29FF) ||
                    ((bus.cmd_word_addr >= 14'h2A00) && (last_idx <= 15'h2DFF));
  assign in_ready_w = (state_reg == ST_WR) && (rem_reg != 14'd0);

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    rem_next       = rem_reg;
    poll_cnt_next  = poll_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    abort_next     = abort_reg;
    out_data_next  = out_data_reg;
    axi_req_next   = 1'b0;
    axi_we_next    = axi_we_reg;
    axi_addr_next  = axi_addr_reg;
    axi_wdata_next = axi_wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_reg) begin
          addr_next     = bus.cmd_word_addr;
          rem_next      = bus.cmd_len;
          abort_next    = 1'b0;
          poll_cnt_next = '0;
          if (bus.cmd_op == OP_RUN) begin
            state_next = ST_RUN_EN;
          end else if (bus.cmd_op == OP_WRITE || bus.cmd_op == OP_READ) begin
            if (bus.cmd_len == 14'd0) begin
              state_next = ST_FIN;
            end else if (!range_ok) begin
              abort_next = 1'b1;
              state_next = ST_FIN;
            end else begin
              state_next = (bus.cmd_op == OP_WRITE) ? ST_WR : ST_RD_REQ;
            end
          end else begin
            abort_next = 1'b1;
            state_next = ST_FIN;
          end
        end
      end
      ST_WR: begin
        if (bus.in_valid && in_ready_w) begin
          axi_req_next   = 1'b1;
          axi_we_next    = 1'b1;
          axi_addr_next  = byte_addr(addr_reg);
          axi_wdata_next = bus.in_data;
          addr_next      = addr_reg + 14'd1;
          rem_next       = rem_reg - 14'd1;
          if (rem_reg == 14'd1) state_next = ST_FIN;
        end
      end
      ST_RD_REQ:  state_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        out_data_next = bus.axi_rdata;
        state_next    = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (bus.out_ready) begin
          addr_next  = addr_reg + 14'd1;
          rem_next   = rem_reg - 14'd1;
          state_next = (rem_reg == 14'd1) ? ST_FIN : ST_RD_REQ;
        end
      end
      ST_RUN_EN:   state_next = ST_POLL_REQ;
      ST_POLL_REQ: state_next = ST_POLL_WAIT;
      ST_POLL_WAIT: begin
        if (bus.axi_rdata[0]) begin
          state_next = ST_RUN_CLR;
        end else if (poll_cnt_reg == PC_W'(TIMEOUT_POLLS - 1)) begin
          abort_next = 1'b1;
          state_next = ST_RUN_CLR;
        end else begin
          poll_cnt_next = poll_cnt_reg + 1'b1;
          gap_cnt_next  = '0;
          state_next    = ST_POLL_GAP;
        end
      end
      ST_POLL_GAP: begin
        if (gap_cnt_reg == GAP_W'(POLL_GAP - 1)) state_next = ST_POLL_REQ;
        else gap_cnt_next = gap_cnt_reg + 1'b1;
      end
      ST_RUN_CLR: state_next = ST_FIN;
      ST_FIN:     state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase

    // Single-cycle request states get their bus access loaded on entry, so req is high while in them.
    case (state_next)
      ST_RD_REQ: begin
        axi_req_next  = 1'b1;
        axi_we_next   = 1'b0;
        axi_addr_next = byte_addr(addr_next);
      end
      ST_RUN_EN, ST_RUN_CLR: begin
        axi_req_next   = 1'b1;
        axi_we_next    = 1'b1;
        axi_addr_next  = byte_addr(EN_IDX);
        axi_wdata_next = (state_next == ST_RUN_EN) ? 64'd1 : 64'd0;
      end
      ST_POLL_REQ: begin
        axi_req_next  = 1'b1;
        axi_we_next   = 1'b0;
        axi_addr_next = byte_addr(FINISH_IDX);
      end
      default: ;
    endcase
    cmd_ready_next = (state_next == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      rem_reg       <= '0;
      poll_cnt_reg  <= '0;
      gap_cnt_reg   <= '0;
      abort_reg     <= 1'b0;
      out_data_reg  <= '0;
      cmd_ready_reg <= 1'b0;
      axi_req_reg   <= 1'b0;
      axi_we_reg    <= 1'b0;
      axi_addr_reg  <= '0;
      axi_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      rem_reg       <= rem_next;
      poll_cnt_reg  <= poll_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      abort_reg     <= abort_next;
      out_data_reg  <= out_data_next;
      cmd_ready_reg <= cmd_ready_next;
      axi_req_reg   <= axi_req_next;
      axi_we_reg    <= axi_we_next;
      axi_addr_reg  <= axi_addr_next;
      axi_wdata_reg <= axi_wdata_next;
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_reg == ST_RD_OUT);
  assign bus.out_data  = out_data_reg;
  assign bus.axi_req   = axi_req_reg;
  assign bus.axi_we    = axi_we_reg;
  assign bus.axi_addr  = axi_addr_reg;
  assign bus.axi_wdata = axi_wdata_reg;
  assign bus.busy      = (state_reg != ST_IDLE) && (state_reg != ST_FIN);
  assign bus.done      = (state_reg == ST_FIN);
  assign bus.err       = (state_reg == ST_FIN) && abort_reg;
endmodule

// File: tb/tb_tpu_host_dma.sv
// Bench for tpu_host_dma: tpu bus model with 1-cycle read latency and a
// controllable FINISH register, plus queue-based scoreboards per scenario.
module tb_tpu_host_dma;
  localparam logic [63:0] BASE = 64'h4000_0000;
  localparam logic [63:0] EN_A = 64'h4001_7000;
  localparam logic [63:0] FN_A = 64'h4001_7008;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } bus_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_host_dma_if bus();
  tpu_host_dma #(.BASE_ADDR(BASE), .POLL_GAP(8), .TIMEOUT_POLLS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  bus_t        bus_log[$];
  bus_t        exp_bus[$];
  logic [63:0] out_log[$];
  logic [63:0] exp_out[$];
  int          done_cyc[$];
  logic        done_err[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          en_cyc = 0;
  int          stall_viol = 0;
  bit          finish_mode = 1'b0;
  logic [63:0] mem [0:16383];
  logic [63:0] byte_off;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [63:0] prev_data = '0;

  assign byte_off = bus.axi_addr - BASE;

  // tpu bus model: read data appears only in the cycle after the request.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.axi_rdata <= JUNK;
    if (bus.axi_req && bus.axi_we && bus.axi_addr == EN_A && bus.axi_wdata[0]) en_cyc <= cyc;
    if (bus.axi_req && !bus.axi_we) begin
      if (bus.axi_addr == FN_A) bus.axi_rdata <= {63'd0, finish_mode && (cyc >= en_cyc + 30)};
      else bus.axi_rdata <= mem[byte_off[16:3]];
    end
  end

  always @(negedge clk) begin
    if (bus.axi_req) begin
      bus_log.push_back('{bus.axi_we, bus.axi_addr, bus.axi_wdata, cyc});
      $display("bus  cyc=%0d we=%0d addr=%h data=%h", cyc, bus.axi_we, bus.axi_addr, bus.axi_wdata);
    end
    if (bus.done) begin
      done_cyc.push_back(cyc);
      done_err.push_back(bus.err);
      $display("done cyc=%0d err=%0d", cyc, bus.err);
    end
    if (bus.out_valid && bus.out_ready) begin
      out_log.push_back(bus.out_data);
      $display("out  cyc=%0d data=%h", cyc, bus.out_data);
    end
    if (prev_valid && !prev_ready && (!bus.out_valid || bus.out_data !== prev_data)) stall_viol++;
    prev_valid = bus.out_valid;
    prev_ready = bus.out_ready;
    prev_data  = bus.out_data;
  end

  function automatic bit outputs_zero();
    return bus.cmd_ready === 1'b0 && bus.busy === 1'b0 && bus.done === 1'b0 && bus.err === 1'b0 &&
           bus.in_ready === 1'b0 && bus.out_valid === 1'b0 && bus.out_data === 64'd0 &&
           bus.axi_req === 1'b0 && bus.axi_we === 1'b0 && bus.axi_addr === 64'd0 && bus.axi_wdata === 64'd0;
  endfunction

  task automatic clear_logs();
    bus_log.delete(); exp_bus.delete(); out_log.delete(); exp_out.delete();
    done_cyc.delete(); done_err.delete();
    stall_viol = 0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [13:0] a, input logic [13:0] l,
                          output int acc_cyc);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_word_addr = a; bus.cmd_len = l;
    while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int n = 0;
    while (done_cyc.size() == 0 && n < limit) begin @(posedge clk); #1; n++; end
    ok = (done_cyc.size() != 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (!outputs_zero()) begin errors++; $display("FAIL reset_outputs busy=%0d cmd_ready=%0d req=%0d (all must be 0)", bus.busy, bus.cmd_ready, bus.axi_req); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_after_reset got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_write();
    int acc; bit ok; bus_t e, g; int n; int c0;
    clear_logs();
    for (int i = 0; i < 4; i++) exp_bus.push_back('{1'b1, BASE + 64'(i * 8), 64'hA5A5_A5A5_A5A5_0000 + 64'(i), 0});
    send_cmd(2'd0, 14'h0000, 14'd4, acc);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 64'hA5A5_A5A5_A5A5_0000 + 64'(i);
      n = 0;
      while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_done(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL write_done_timeout got=none exp=done"); end
    checks++;
    if (bus_log.size() != 4) begin errors++; $display("FAIL write_count got=%0d exp=4", bus_log.size()); end
    c0 = (bus_log.size() > 0) ? bus_log[0].cyc : 0;
    for (int i = 0; exp_bus.size() > 0 && bus_log.size() > 0; i++) begin
      e = exp_bus.pop_front(); g = bus_log.pop_front();
      checks++;
      if (g.we !== e.we || g.addr !== e.addr || g.data !== e.data || g.cyc != c0 + i)
        begin errors++; $display("FAIL write_txn%0d got we=%0d addr=%h data=%h cyc=%0d exp we=%0d addr=%h data=%h cyc=%0d", i, g.we, g.addr, g.data, g.cyc, e.we, e.addr, e.data, c0 + i); end
    end
    checks++;
    if (done_err.size() == 0 || done_err[0] !== 1'b0) begin errors++; $display("FAIL write_err got=%0d exp=0", (done_err.size() > 0) ? done_err[0] : 1'bx); end
  endtask

  task automatic test_read();
    int acc; int k; bus_t e, g; logic [63:0] eo, go;
    logic [3:0] pat;
    clear_logs();
    pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      mem[14'h29FC + i] = 64'hC0DE_0000_0000_0000 + 64'(i * 7 + 3);
      exp_bus.push_back('{1'b0, BASE + 64'((14'h29FC + i) * 8), 64'd0, 0});
      exp_out.push_back(64'hC0DE_0000_0000_0000 + 64'(i * 7 + 3));
    end
    bus.out_ready = 1'b1;
    send_cmd(2'd1, 14'h29FC, 14'd4, acc);
    k = 0;
    while (done_cyc.size() == 0 && k < 100) begin bus.out_ready = pat[k % 4]; @(posedge clk); #1; k++; end
    bus.out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (done_cyc.size() != 1 || done_err[0] !== 1'b0) begin errors++; $display("FAIL read_done got=%0d dones exp=1 with err=0", done_cyc.size()); end
    checks++;
    if (bus_log.size() != 4 || out_log.size() != 4) begin errors++; $display("FAIL read_counts got reqs=%0d outs=%0d exp 4/4", bus_log.size(), out_log.size()); end
    while (exp_bus.size() > 0 && bus_log.size() > 0) begin
      e = exp_bus.pop_front(); g = bus_log.pop_front();
      checks++;
      if (g.we !== 1'b0 || g.addr !== e.addr) begin errors++; $display("FAIL read_req got we=%0d addr=%h exp we=0 addr=%h", g.we, g.addr, e.addr); end
    end
    while (exp_out.size() > 0 && out_log.size() > 0) begin
      eo = exp_out.pop_front(); go = out_log.pop_front();
      checks++;
      if (go !== eo) begin errors++; $display("FAIL read_data got=%h exp=%h", go, eo); end
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL read_stall_stable got=%0d violations exp=0", stall_viol); end
  endtask

  task automatic test_run(input bit fin, input int exp_polls, input logic exp_err);
    int acc; bit ok; int np; int lim;
    clear_logs();
    finish_mode = fin;
    send_cmd(2'd2, 14'd0, 14'd0, acc);
    wait_done(400, ok);
    finish_mode = 1'b0;
    checks++;
    if (!ok || done_err[0] !== exp_err) begin errors++; $display("FAIL run_done fin=%0d got done=%0d err=%0d exp done=1 err=%0d", fin, ok, ok ? done_err[0] : 1'bx, exp_err); end
    np = bus_log.size() - 2;
    checks++;
    if (np != exp_polls) begin errors++; $display("FAIL run_poll_count fin=%0d got=%0d exp=%0d", fin, np, exp_polls); end
    if (bus_log.size() >= 2) begin
      lim = bus_log[0].cyc + 30;
      checks++;
      if (bus_log[0].we !== 1'b1 || bus_log[0].addr !== EN_A || bus_log[0].data !== 64'd1)
        begin errors++; $display("FAIL run_en_set got we=%0d addr=%h data=%h exp we=1 addr=%h data=1", bus_log[0].we, bus_log[0].addr, bus_log[0].data, EN_A); end
      checks++;
      if (bus_log[$].we !== 1'b1 || bus_log[$].addr !== EN_A || bus_log[$].data !== 64'd0)
        begin errors++; $display("FAIL run_en_clr got we=%0d addr=%h data=%h exp we=1 addr=%h data=0", bus_log[$].we, bus_log[$].addr, bus_log[$].data, EN_A); end
      for (int i = 1; i < bus_log.size() - 1; i++) begin
        checks++;
        if (bus_log[i].we !== 1'b0 || bus_log[i].addr !== FN_A || (i > 1 && bus_log[i].cyc - bus_log[i-1].cyc != 10))
          begin errors++; $display("FAIL run_poll%0d got we=%0d addr=%h gap=%0d exp we=0 addr=%h gap=10", i, bus_log[i].we, bus_log[i].addr, bus_log[i].cyc - bus_log[i-1].cyc, FN_A); end
      end
      if (fin && bus_log.size() >= 4) begin
        checks++;
        if (bus_log[$-1].cyc < lim || bus_log[$-2].cyc >= lim)
          begin errors++; $display("FAIL run_finish_seen got last_poll=%0d prev_poll=%0d exp first poll at/after %0d", bus_log[$-1].cyc, bus_log[$-2].cyc, lim); end
      end
    end
  endtask

  task automatic test_reject();
    int acc; bit ok;
    logic [1:0]  ops[4]   = '{2'd0, 2'd3, 2'd1, 2'd0};
    logic [13:0] addrs[4] = '{14'h29FE, 14'h0000, 14'h2DFF, 14'h0010};
    logic [13:0] lens[4]  = '{14'd4, 14'd1, 14'd2, 14'd0};
    logic        errs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 4; t++) begin
      clear_logs();
      bus.in_valid = 1'b1; bus.in_data = 64'h1234;
      send_cmd(ops[t], addrs[t], lens[t], acc);
      wait_done(10, ok);
      bus.in_valid = 1'b0;
      checks++;
      if (!ok || done_cyc[0] != acc || done_err[0] !== errs[t])
        begin errors++; $display("FAIL reject%0d got done=%0d cyc=%0d err=%0d exp done=1 cyc=%0d err=%0d", t, ok, ok ? done_cyc[0] : -1, ok ? done_err[0] : 1'bx, acc, errs[t]); end
      checks++;
      if (bus_log.size() != 0 || done_cyc.size() != 1) begin errors++; $display("FAIL reject%0d_traffic got reqs=%0d dones=%0d exp 0/1", t, bus_log.size(), done_cyc.size()); end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    clear_logs();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_word_addr = 14'd0; bus.cmd_len = 14'd0;
    while (done_cyc.size() < 2 && n < 20) begin @(posedge clk); #1; n++; end
    bus.cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (done_cyc.size() < 2 || done_cyc[1] - done_cyc[0] != 2)
      begin errors++; $display("FAIL back_to_back got dones=%0d spacing=%0d exp spacing=2", done_cyc.size(), (done_cyc.size() >= 2) ? done_cyc[1] - done_cyc[0] : -1); end
  endtask

  task automatic test_reset_mid();
    int acc; int n = 0; bit ok; logic [63:0] eo, go;
    clear_logs();
    mem[14'h0100] = 64'h0BAD_F00D_0000_0001;
    mem[14'h0101] = 64'h0BAD_F00D_0000_0002;
    bus.out_ready = 1'b0;
    send_cmd(2'd1, 14'h0100, 14'd2, acc);
    while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_reach_rd_out got=%b exp=1", bus.out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (!outputs_zero()) begin errors++; $display("FAIL rst_mid_outputs busy=%0d out_valid=%0d req=%0d (all must be 0)", bus.busy, bus.out_valid, bus.axi_req); end
    rst = 1'b0; bus.out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (done_cyc.size() != 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", done_cyc.size()); end
    clear_logs();
    exp_out.push_back(64'h0BAD_F00D_0000_0001);
    exp_out.push_back(64'h0BAD_F00D_0000_0002);
    send_cmd(2'd1, 14'h0100, 14'd2, acc);
    wait_done(50, ok);
    checks++;
    if (!ok || done_err[0] !== 1'b0 || out_log.size() != 2 || bus_log.size() != 2)
      begin errors++; $display("FAIL rst_mid_fresh_read got done=%0d outs=%0d reqs=%0d exp 1/2/2", ok, out_log.size(), bus_log.size()); end
    while (exp_out.size() > 0 && out_log.size() > 0) begin
      eo = exp_out.pop_front(); go = out_log.pop_front();
      checks++;
      if (go !== eo) begin errors++; $display("FAIL rst_mid_data got=%h exp=%h", go, eo); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_word_addr = '0; bus.cmd_len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_run(1'b1, 4, 1'b0);
    test_run(1'b0, 4, 1'b1);
    test_reject();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
